// File: rtl/shot_pkg.sv
// shot_pkg: shared state type, coordinate widths and player id for the shot arbiter
package shot_pkg;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_CMP, S_DONE} state_t;
  typedef logic player_t;
endpackage

// File: rtl/shot_arbiter_hit_cmp.sv
// hit_cmp: box test of a shot point against one target table entry
module hit_cmp
  import shot_pkg::*;
#(
  parameter int HIT_R = 16
) (
  input  logic [X_W-1:0] sx,
  input  logic [Y_W-1:0] sy,
  input  logic [X_W-1:0] tx,
  input  logic [Y_W-1:0] ty,
  input  logic           alive,
  output logic           hit
);
  logic signed [10:0] dx, dy;
  logic [10:0] ax, ay;
  assign dx = $signed({1'b0, tx}) - $signed({1'b0, sx});
  assign dy = $signed({2'b0, ty}) - $signed({2'b0, sy});
  assign ax = dx[10] ? -dx : dx;
  assign ay = dy[10] ? -dy : dy;
  assign hit = alive && ax <= 11'(HIT_R) && ay <= 11'(HIT_R);
endmodule

// File: rtl/shot_arbiter.sv
// shot_arbiter: round-robin sharing of the target hit-test scan between two guns
module shot_arbiter
  import shot_pkg::*;
#(
  parameter int NUM_TGT = 8,
  parameter int IDX_W   = 3,
  parameter int HIT_R   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shot0,
  input  logic [X_W-1:0]   shoot_x0,
  input  logic [Y_W-1:0]   shoot_y0,
  input  logic             shot1,
  input  logic [X_W-1:0]   shoot_x1,
  input  logic [Y_W-1:0]   shoot_y1,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [X_W-1:0]   rd_x,
  input  logic [Y_W-1:0]   rd_y,
  input  logic             rd_alive,
  output logic             kill,
  output logic [IDX_W-1:0] kill_idx,
  output logic             done,
  output logic             done_hit,
  output logic             done_player,
  output logic             busy,
  output logic [1:0]       drop
);
  state_t state;
  logic [1:0] slot_v, shot, grant;
  logic [X_W-1:0] slot_x [2];
  logic [Y_W-1:0] slot_y [2];
  logic [X_W-1:0] shot_x [2];
  logic [Y_W-1:0] shot_y [2];
  logic [X_W-1:0] sx;
  logic [Y_W-1:0] sy;
  logic [IDX_W-1:0] idx;
  player_t last_grant, work_p;
  logic hit, last;
  assign shot = {shot1, shot0};
  assign shot_x[0] = shoot_x0;
  assign shot_x[1] = shoot_x1;
  assign shot_y[0] = shoot_y0;
  assign shot_y[1] = shoot_y1;
  assign grant[1] = state == S_IDLE && slot_v[1] && (!slot_v[0] || last_grant == 1'b0);
  assign grant[0] = state == S_IDLE && slot_v[0] && !grant[1];
  assign last = idx == IDX_W'(NUM_TGT - 1);
  assign busy = state != S_IDLE;
  assign rd_idx = idx;
  hit_cmp #(.HIT_R(HIT_R)) u_cmp (
    .sx(sx), .sy(sy), .tx(rd_x), .ty(rd_y), .alive(rd_alive), .hit(hit)
  );
  // pending slots: a shot loads an empty or just-granted slot, otherwise it is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_v <= '0;
      drop <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        drop[i] <= shot[i] && slot_v[i] && !grant[i];
        if (shot[i] && (!slot_v[i] || grant[i])) begin
          slot_v[i] <= 1'b1;
          slot_x[i] <= shot_x[i];
          slot_y[i] <= shot_y[i];
        end else if (grant[i]) begin
          slot_v[i] <= 1'b0;
        end
      end
    end
  end
  // scan FSM: grant a slot, alternate address/compare per target, report once
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      last_grant <= 1'b1;
      work_p <= 1'b0;
      sx <= '0;
      sy <= '0;
      idx <= '0;
      done <= 1'b0;
      done_hit <= 1'b0;
      done_player <= 1'b0;
      kill <= 1'b0;
      kill_idx <= '0;
    end else begin
      done <= 1'b0;
      kill <= 1'b0;
      case (state)
        S_IDLE: if (|grant) begin
          work_p <= grant[1];
          last_grant <= grant[1];
          sx <= slot_x[grant[1]];
          sy <= slot_y[grant[1]];
          idx <= '0;
          state <= S_ADDR;
        end
        S_ADDR: state <= S_CMP;
        S_CMP: if (hit || last) begin
          done <= 1'b1;
          done_hit <= hit;
          done_player <= work_p;
          kill <= hit;
          kill_idx <= hit ? idx : kill_idx;
          state <= S_DONE;
        end else begin
          idx <= idx + 1'b1;
          state <= S_ADDR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
